// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 stream-cipher engine.
package rc4_pkg;

   localparam int SBOX_DEPTH    = 256;
   localparam int MAX_KEY_BYTES = 256;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {IDLE, LOAD_KEY, INIT, KSA, PRGA, DONE} state_t;

   typedef enum logic {KSA_ACCUM, KSA_SWAP} ksa_step_t;

   typedef enum logic [1:0] {PRGA_ADVANCE, PRGA_SWAP, PRGA_FETCH, PRGA_EMIT} prga_step_t;

endpackage

// File: rtl/rc4_sbox_mem.sv
// 256x8 S-box register array: two combinational read ports and two write
// ports so a swap of S[a] and S[b] completes in a single cycle.
module rc4_sbox_mem
   import rc4_pkg::*;
(
   input  logic       i_clk,
   input  logic [7:0] i_addrA,
   input  logic [7:0] i_addrB,
   input  logic       i_weA,
   input  logic       i_weB,
   input  logic [7:0] i_wdataA,
   input  logic [7:0] i_wdataB,
   output logic [7:0] o_dataA,
   output logic [7:0] o_dataB
);

   byte_t r_mem [SBOX_DEPTH];

   // When both ports hit the same address during a swap they carry the same value.
   always_ff @(posedge i_clk) begin
      if (i_weA) r_mem[i_addrA] <= i_wdataA;
      if (i_weB) r_mem[i_addrB] <= i_wdataB;
   end

   assign o_dataA = r_mem[i_addrA];
   assign o_dataB = r_mem[i_addrB];

endmodule

// File: rtl/rc4_0.sv
// RC4 engine with ap_ctrl_hs handshake: loads the key, runs KSA, then
// XORs each plaintext byte with the PRGA keystream into the ciphertext FIFO.
module rc4_0
   import rc4_pkg::*;
(
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        ap_start,
   output logic        ap_done,
   output logic        ap_idle,
   output logic        ap_ready,
   input  logic [15:0] key_size_in,
   input  logic [31:0] plaintext_size_in,
   input  logic [7:0]  key_in_V_dout,
   input  logic        key_in_V_empty_n,
   output logic        key_in_V_read,
   input  logic [7:0]  plaintext_in_V_dout,
   input  logic        plaintext_in_V_empty_n,
   output logic        plaintext_in_V_read,
   output logic [7:0]  ciphertext_out_V_din,
   input  logic        ciphertext_out_V_full_n,
   output logic        ciphertext_out_V_write
);

   state_t     r_state;
   ksa_step_t  r_ksaStep;
   prga_step_t r_prgaStep;
   byte_t      r_i, r_j, r_t, r_kidx, r_kcnt, r_ct;
   logic [8:0] r_keyLen;
   logic       r_zeroKey;
   logic [31:0] r_ptLeft;
   logic       r_done, r_idle;
   byte_t      r_key [MAX_KEY_BYTES];

   byte_t      w_addrA, w_addrB, w_dataA, w_dataB, w_wdataA, w_wdataB, w_iNext;
   logic       w_weA, w_weB, w_keyWr, w_ptPop, w_ctPush, w_lastKey, w_swap;
   logic [8:0] w_keyLenIn;

   assign w_iNext    = r_i + 8'd1;
   assign w_keyLenIn = (key_size_in > 16'(MAX_KEY_BYTES)) ? 9'(MAX_KEY_BYTES) : key_size_in[8:0];
   assign w_keyWr    = (r_state == LOAD_KEY) && !r_zeroKey && key_in_V_empty_n;
   assign w_ptPop    = (r_state == PRGA) && (r_prgaStep == PRGA_FETCH) && plaintext_in_V_empty_n;
   assign w_ctPush   = (r_state == PRGA) && (r_prgaStep == PRGA_EMIT) && ciphertext_out_V_full_n;
   assign w_lastKey  = ({1'b0, r_kcnt} == r_keyLen - 9'd1);
   assign w_swap     = ((r_state == KSA) && (r_ksaStep == KSA_SWAP)) ||
                       ((r_state == PRGA) && (r_prgaStep == PRGA_SWAP));

   // Port A follows i (or the keystream index), port B follows j.
   always_comb begin
      w_addrA  = r_i;
      w_addrB  = r_j;
      w_weA    = 1'b0;
      w_weB    = 1'b0;
      w_wdataA = w_dataB;
      w_wdataB = w_dataA;
      if (r_state == INIT) begin
         w_weA    = 1'b1;
         w_wdataA = r_i;
      end else if (w_swap) begin
         w_weA = 1'b1;
         w_weB = 1'b1;
      end else if ((r_state == PRGA) && (r_prgaStep == PRGA_ADVANCE)) begin
         w_addrA = w_iNext;
      end else if ((r_state == PRGA) && (r_prgaStep == PRGA_FETCH)) begin
         w_addrA = r_t;
      end
   end

   rc4_sbox_mem u_sbox (
      .i_clk    (ap_clk),
      .i_addrA  (w_addrA),
      .i_addrB  (w_addrB),
      .i_weA    (w_weA),
      .i_weB    (w_weB),
      .i_wdataA (w_wdataA),
      .i_wdataB (w_wdataB),
      .o_dataA  (w_dataA),
      .o_dataB  (w_dataB)
   );

   // A zero-length key behaves as a single zero byte.
   always_ff @(posedge ap_clk) begin
      if (w_keyWr)
         r_key[r_kcnt] <= key_in_V_dout;
      else if ((r_state == LOAD_KEY) && r_zeroKey)
         r_key[0] <= 8'd0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state    <= IDLE;
         r_ksaStep  <= KSA_ACCUM;
         r_prgaStep <= PRGA_ADVANCE;
         r_i        <= 8'd0;
         r_j        <= 8'd0;
         r_t        <= 8'd0;
         r_kidx     <= 8'd0;
         r_kcnt     <= 8'd0;
         r_ct       <= 8'd0;
         r_keyLen   <= 9'd1;
         r_zeroKey  <= 1'b0;
         r_ptLeft   <= 32'd0;
         r_done     <= 1'b0;
         r_idle     <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ap_start) begin
                  r_state   <= LOAD_KEY;
                  r_idle    <= 1'b0;
                  r_keyLen  <= (w_keyLenIn == 9'd0) ? 9'd1 : w_keyLenIn;
                  r_zeroKey <= (w_keyLenIn == 9'd0);
                  r_ptLeft  <= plaintext_size_in;
                  r_kcnt    <= 8'd0;
                  r_i       <= 8'd0;
                  r_j       <= 8'd0;
               end
            end
            LOAD_KEY: begin
               if (r_zeroKey) begin
                  r_state <= INIT;
               end else if (key_in_V_empty_n) begin
                  r_kcnt <= r_kcnt + 8'd1;
                  if (w_lastKey) r_state <= INIT;
               end
            end
            INIT: begin
               r_i <= w_iNext;
               if (r_i == 8'hFF) begin
                  r_state   <= KSA;
                  r_ksaStep <= KSA_ACCUM;
                  r_j       <= 8'd0;
                  r_kidx    <= 8'd0;
               end
            end
            KSA: begin
               if (r_ksaStep == KSA_ACCUM) begin
                  r_j       <= r_j + w_dataA + r_key[r_kidx];
                  r_ksaStep <= KSA_SWAP;
               end else begin
                  r_ksaStep <= KSA_ACCUM;
                  r_i       <= w_iNext;
                  r_kidx    <= ({1'b0, r_kidx} == r_keyLen - 9'd1) ? 8'd0 : r_kidx + 8'd1;
                  if (r_i == 8'hFF) begin
                     r_j <= 8'd0;
                     if (r_ptLeft == 32'd0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= PRGA;
                        r_prgaStep <= PRGA_ADVANCE;
                     end
                  end
               end
            end
            PRGA: begin
               // The index sum survives the swap, so it is captured before S changes.
               case (r_prgaStep)
                  PRGA_ADVANCE: begin
                     r_i        <= w_iNext;
                     r_j        <= r_j + w_dataA;
                     r_prgaStep <= PRGA_SWAP;
                  end
                  PRGA_SWAP: begin
                     r_t        <= w_dataA + w_dataB;
                     r_prgaStep <= PRGA_FETCH;
                  end
                  PRGA_FETCH: begin
                     if (plaintext_in_V_empty_n) begin
                        r_ct       <= plaintext_in_V_dout ^ w_dataA;
                        r_prgaStep <= PRGA_EMIT;
                     end
                  end
                  PRGA_EMIT: begin
                     if (ciphertext_out_V_full_n) begin
                        r_ptLeft   <= r_ptLeft - 32'd1;
                        r_prgaStep <= PRGA_ADVANCE;
                        if (r_ptLeft == 32'd1) begin
                           r_state <= DONE;
                           r_done  <= 1'b1;
                        end
                     end
                  end
                  default: r_prgaStep <= PRGA_ADVANCE;
               endcase
            end
            DONE: begin
               r_state <= IDLE;
               r_idle  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ap_done                = r_done;
   assign ap_ready               = r_done;
   assign ap_idle                = r_idle;
   assign key_in_V_read          = w_keyWr;
   assign plaintext_in_V_read    = w_ptPop;
   assign ciphertext_out_V_write = w_ctPush;
   assign ciphertext_out_V_din   = r_ct;

endmodule

// File: tb/tb_rc4_0.sv
// Directed bench for rc4_0: FIFO models with optional random stalls feed the
// engine, and a scoreboard queue holds the expected ciphertext bytes.
module tb_rc4_0;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        ap_start = 1'b0;
   logic        ap_done, ap_idle, ap_ready;
   logic [15:0] key_size_in = 16'd0;
   logic [31:0] plaintext_size_in = 32'd0;
   logic [7:0]  key_in_V_dout = 8'd0;
   logic        key_in_V_empty_n = 1'b0;
   logic        key_in_V_read;
   logic [7:0]  plaintext_in_V_dout = 8'd0;
   logic        plaintext_in_V_empty_n = 1'b0;
   logic        plaintext_in_V_read;
   logic [7:0]  ciphertext_out_V_din;
   logic        ciphertext_out_V_full_n = 1'b1;
   logic        ciphertext_out_V_write;

   localparam logic [255:0] K32 = 256'hae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405;
   localparam logic [255:0] P32 = 256'h3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595;
   localparam logic [255:0] C32 = 256'h2280c9676c8f5c52aba8d42611f85e7ca961a2117d3cfc8236a6051bbfc5f179;
   localparam logic [255:0] KKEY = 256'h4b6579;
   localparam logic [255:0] PKEY = 256'h506c61696e74657874;
   localparam logic [255:0] CKEY = 256'hbbf316e8d940af0ad3;

   logic [7:0]  keyQ[$];
   logic [7:0]  ptQ[$];
   logic [7:0]  expQ[$];
   int unsigned stallPct = 0;
   int          vectorCount = 0;
   int          missCount = 0;
   int          writeCount = 0;
   int          ptReadCount = 0;
   int          doneCount = 0;

   rc4_0 dut (
      .ap_clk                  (ap_clk),
      .ap_rst_n                (ap_rst_n),
      .ap_start                (ap_start),
      .ap_done                 (ap_done),
      .ap_idle                 (ap_idle),
      .ap_ready                (ap_ready),
      .key_size_in             (key_size_in),
      .plaintext_size_in       (plaintext_size_in),
      .key_in_V_dout           (key_in_V_dout),
      .key_in_V_empty_n        (key_in_V_empty_n),
      .key_in_V_read           (key_in_V_read),
      .plaintext_in_V_dout     (plaintext_in_V_dout),
      .plaintext_in_V_empty_n  (plaintext_in_V_empty_n),
      .plaintext_in_V_read     (plaintext_in_V_read),
      .ciphertext_out_V_din    (ciphertext_out_V_din),
      .ciphertext_out_V_full_n (ciphertext_out_V_full_n),
      .ciphertext_out_V_write  (ciphertext_out_V_write)
   );

   initial forever #5 ap_clk = ~ap_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Loads the FIFO models and the scoreboard; sizes are optionally presented too.
   task automatic applyStimulus(input logic [255:0] key, input int keyLen,
                                input logic [255:0] pt, input logic [255:0] ct,
                                input int ptLen, input bit setSizes);
      for (int n = 0; n < keyLen; n++) keyQ.push_back(key[8*(keyLen-1-n) +: 8]);
      for (int n = 0; n < ptLen; n++) begin
         ptQ.push_back(pt[8*(ptLen-1-n) +: 8]);
         expQ.push_back(ct[8*(ptLen-1-n) +: 8]);
      end
      if (setSizes) begin
         key_size_in       = 16'(keyLen);
         plaintext_size_in = 32'(ptLen);
      end
   endtask

   task automatic waitDone(input string tag, input int budget);
      int cyc = 0;
      while (!ap_done && cyc < budget) begin
         @(negedge ap_clk);
         cyc++;
      end
      checkOutput(tag, {31'd0, ap_done}, 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_idle"}, {31'd0, ap_idle}, 32'd1);
      checkOutput({tag, "_done"}, {31'd0, ap_done}, 32'd0);
      checkOutput({tag, "_ready"}, {31'd0, ap_ready}, 32'd0);
      checkOutput({tag, "_keyRead"}, {31'd0, key_in_V_read}, 32'd0);
      checkOutput({tag, "_ptRead"}, {31'd0, plaintext_in_V_read}, 32'd0);
      checkOutput({tag, "_write"}, {31'd0, ciphertext_out_V_write}, 32'd0);
      checkOutput({tag, "_din"}, {24'd0, ciphertext_out_V_din}, 32'd0);
   endtask

   // FIFO models and scoreboard: sample strobes mid-cycle, pop/redrive just after the edge.
   initial begin : fifoModel
      logic       rdKey, rdPt;
      logic [7:0] exp, junk;
      forever begin
         @(negedge ap_clk);
         rdKey = key_in_V_read;
         rdPt  = plaintext_in_V_read;
         if (ap_rst_n) begin
            if (rdKey) checkOutput("keyReadWhileEmpty", {31'd0, key_in_V_empty_n}, 32'd1);
            if (rdPt) begin
               checkOutput("ptReadWhileEmpty", {31'd0, plaintext_in_V_empty_n}, 32'd1);
               ptReadCount++;
            end
            if (ciphertext_out_V_write) begin
               checkOutput("writeWhileFull", {31'd0, ciphertext_out_V_full_n}, 32'd1);
               checkOutput("scoreboardNonEmpty", {31'd0, expQ.size() != 0}, 32'd1);
               if (expQ.size() != 0) begin
                  exp = expQ.pop_front();
                  checkOutput("ciphertext", {24'd0, ciphertext_out_V_din}, {24'd0, exp});
               end
               writeCount++;
            end
            if (ap_done) begin
               checkOutput("readyWithDone", {31'd0, ap_ready}, 32'd1);
               doneCount++;
            end
         end
         @(posedge ap_clk);
         #1;
         if (rdKey && keyQ.size() != 0) junk = keyQ.pop_front();
         if (rdPt && ptQ.size() != 0) junk = ptQ.pop_front();
         key_in_V_empty_n        = (keyQ.size() != 0) && ($urandom_range(99) >= stallPct);
         key_in_V_dout           = (keyQ.size() != 0) ? keyQ[0] : 8'h00;
         plaintext_in_V_empty_n  = (ptQ.size() != 0) && ($urandom_range(99) >= stallPct);
         plaintext_in_V_dout     = (ptQ.size() != 0) ? ptQ[0] : 8'h00;
         ciphertext_out_V_full_n = ($urandom_range(99) >= stallPct);
      end
   end

   initial begin : directedSteps
      int baseDone, baseWrite, basePt, cyc;

      $display("[TB] reset");
      ap_rst_n = 1'b1;
      #1 ap_rst_n = 1'b0;
      repeat (3) @(negedge ap_clk);
      checkResetOutputs("reset");
      @(posedge ap_clk);
      #1 ap_rst_n = 1'b1;
      @(negedge ap_clk);

      $display("[TB] 32-byte vector, no stalls");
      baseDone = doneCount;
      applyStimulus(K32, 32, P32, C32, 32, 1'b1);
      ap_start = 1'b1;
      waitDone("done32Within2000", 2000);
      ap_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("run32Drained", expQ.size(), 32'd0);
      checkOutput("run32KeyConsumed", keyQ.size(), 32'd0);
      checkOutput("run32DonePulses", doneCount - baseDone, 32'd1);
      checkOutput("run32IdleAfter", {31'd0, ap_idle}, 32'd1);

      $display("[TB] Key / Plaintext vector");
      baseWrite = writeCount;
      applyStimulus(KKEY, 3, PKEY, CKEY, 9, 1'b1);
      ap_start = 1'b1;
      waitDone("doneKeyVec", 2000);
      ap_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("keyVecDrained", expQ.size(), 32'd0);
      checkOutput("keyVecWrites", writeCount - baseWrite, 32'd9);

      $display("[TB] 32-byte vector with random stalls");
      stallPct = 35;
      baseWrite = writeCount;
      applyStimulus(K32, 32, P32, C32, 32, 1'b1);
      ap_start = 1'b1;
      waitDone("doneStalled", 8000);
      ap_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("stalledDrained", expQ.size(), 32'd0);
      checkOutput("stalledWrites", writeCount - baseWrite, 32'd32);
      stallPct = 0;

      $display("[TB] zero-length plaintext");
      baseDone = doneCount;
      baseWrite = writeCount;
      basePt = ptReadCount;
      applyStimulus(KKEY, 3, 256'd0, 256'd0, 0, 1'b1);
      plaintext_size_in = 32'd0;
      for (int n = 0; n < 4; n++) ptQ.push_back(8'h11);
      ap_start = 1'b1;
      waitDone("doneZeroPt", 2000);
      ap_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("zeroPtReads", ptReadCount - basePt, 32'd0);
      checkOutput("zeroPtFifoUntouched", ptQ.size(), 32'd4);
      checkOutput("zeroPtWrites", writeCount - baseWrite, 32'd0);
      checkOutput("zeroPtDonePulses", doneCount - baseDone, 32'd1);
      checkOutput("zeroPtIdle", {31'd0, ap_idle}, 32'd1);
      ptQ.delete();

      $display("[TB] back-to-back runs with ap_start held");
      baseDone = doneCount;
      baseWrite = writeCount;
      applyStimulus(KKEY, 3, PKEY, CKEY, 9, 1'b1);
      applyStimulus(K32, 32, P32, C32, 32, 1'b0);
      ap_start = 1'b1;
      repeat (5) @(negedge ap_clk);
      key_size_in       = 16'd32;
      plaintext_size_in = 32'd32;
      waitDone("b2bFirstDone", 2000);
      @(negedge ap_clk);
      waitDone("b2bSecondDone", 2000);
      ap_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("b2bDrained", expQ.size(), 32'd0);
      checkOutput("b2bWrites", writeCount - baseWrite, 32'd41);
      checkOutput("b2bDonePulses", doneCount - baseDone, 32'd2);

      $display("[TB] reset during PRGA");
      baseWrite = writeCount;
      applyStimulus(K32, 32, P32, C32, 32, 1'b1);
      ap_start = 1'b1;
      cyc = 0;
      while (writeCount < baseWrite + 5 && cyc < 3000) begin
         @(negedge ap_clk);
         cyc++;
      end
      checkOutput("reachedPrga", {31'd0, writeCount >= baseWrite + 5}, 32'd1);
      #2 ap_rst_n = 1'b0;
      ap_start = 1'b0;
      #1;
      checkResetOutputs("midReset");
      keyQ.delete();
      ptQ.delete();
      expQ.delete();
      repeat (3) @(negedge ap_clk);
      @(posedge ap_clk);
      #1 ap_rst_n = 1'b1;
      @(negedge ap_clk);
      baseWrite = writeCount;
      applyStimulus(KKEY, 3, PKEY, CKEY, 9, 1'b1);
      ap_start = 1'b1;
      waitDone("afterResetDone", 2000);
      ap_start = 1'b0;
      repeat (2) @(negedge ap_clk);
      checkOutput("afterResetDrained", expQ.size(), 32'd0);
      checkOutput("afterResetWrites", writeCount - baseWrite, 32'd9);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
